instr_sequencer: RTL
====================

# instr_sequencer

Multicycle control sequencer for the MIPS CPU. It steps each instruction through FETCH_INSTR, DECODE, EXECUTE, MEMORY_ACCESS and WRITE_BACK, and inserts wait cycles while the memory bus asserts waitrequest. It drives the program-counter register's `state`, `stall`, `pcctl` and `PCWriteCond` inputs, including branch-delay-slot bookkeeping and halt on jump-to-zero. It sits between the instruction decoder and the PC/IR/register-file write enables.

## Interface
Parameters:
- RESET_STATE, 3'b000, state entered on reset (FETCH_INSTR).

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- waitrequest  input  1  memory busy; holds FETCH_INSTR or MEMORY_ACCESS
- is_mem  input  1  decoded instruction is a load or store; valid DECODE..WRITE_BACK
- is_branch  input  1  decoded instruction is a branch or jump
- branch_taken  input  1  branch condition result; sampled in EXECUTE only
- halt_req  input  1  jump target is 0x00000000; sampled in EXECUTE only
- needs_wb  input  1  instruction writes the register file
- state  output  3  current state; encoding below
- stall  output  1  freeze to the PC and pipeline registers
- pcctl  output  1  PC increment write enable, 1-cycle pulse
- PCWriteCond  output  1  latch branch target into the PC, 1-cycle pulse
- ir_write  output  1  instruction register load, 1-cycle pulse
- reg_write  output  1  register-file write enable
- branch_pending  output  1  taken branch awaiting its delay slot
- active  output  1  CPU running; low once halted
- cycle_count  output  32  see Configuration
- instr_count  output  32  see Configuration

## Operation
State encoding:
- FETCH_INSTR=000
- DECODE=001
- EXECUTE=010
- MEMORY_ACCESS=011
- WRITE_BACK=100
- HALTED=101

Transitions:
- FETCH_INSTR→DECODE when waitrequest=0; otherwise stay in FETCH_INSTR.
- DECODE→EXECUTE unconditionally.
- EXECUTE→MEMORY_ACCESS unconditionally. Every instruction visits MEMORY_ACCESS, because the PC applies a pending branch there.
- MEMORY_ACCESS→WRITE_BACK when !(is_mem && waitrequest); otherwise stay in MEMORY_ACCESS.
- WRITE_BACK→HALTED if halt_armed && !branch_pending_for_this_slot; otherwise →FETCH_INSTR.
- HALTED is absorbing until reset.

Output rules:
- pcctl=ir_write=1 in FETCH_INSTR when waitrequest=0.
- PCWriteCond=1 in EXECUTE when is_branch && branch_taken.
- branch_pending is set on the edge leaving that EXECUTE. It clears on the edge leaving the next instruction's (delay slot's) MEMORY_ACCESS.
- halt_req in EXECUTE (with is_branch) sets halt_armed. The halt takes effect at the WRITE_BACK exit of the delay-slot instruction, i.e. one full instruction later.
- reg_write=needs_wb in WRITE_BACK; 0 elsewhere.
- stall=1 in FETCH_INSTR with waitrequest=1, in MEMORY_ACCESS with is_mem && waitrequest=1, and in HALTED.
- active=0 only in HALTED.

Simultaneous and boundary conditions:
- A taken branch in the delay slot of another taken branch: PCWriteCond pulses again and branch_pending stays 1. The second target wins at the next MEMORY_ACCESS.
- waitrequest is ignored in DECODE, EXECUTE and WRITE_BACK.
- waitrequest is ignored in MEMORY_ACCESS when is_mem=0.

## Timing
- Reset (async, any state, mid-wait included): state=FETCH_INSTR. All pulses, stall, branch_pending and halt_armed are 0; active=1; counters 0.
- Minimum latency is 5 cycles per instruction with zero wait states. Each waitrequest cycle adds exactly one cycle.
- All outputs are decoded from registered state and current inputs. There are no combinational paths from inputs to state.
- Pulses are high for exactly one clock per instruction.

## Configuration
- INSTR_SEQUENCER_PERF_EN defined:
  - cycle_count increments every clock while active=1.
  - instr_count increments on each WRITE_BACK exit.
  - Both wrap modulo 2^32 and are held in HALTED.
- Not defined: both ports are driven constant 0 and no counter flops exist.

## Test plan
- Reset mid-MEMORY_ACCESS with waitrequest=1 → state=000, stall=0, branch_pending=0, active=1 immediately, without waiting for a clock edge.
- Non-memory ALU op, waitrequest=0 → states 000,001,010,011,100,000. pcctl and ir_write pulse in cycle 1; reg_write=1 in cycle 5.
- Load with waitrequest high for 3 cycles in MEMORY_ACCESS → 8 cycles total; stall=1 for exactly those 3 cycles.
- Taken branch → PCWriteCond pulse in EXECUTE. branch_pending=1 through the delay slot's MEMORY_ACCESS, then 0.
- Jump to 0 (halt_req=1) → delay slot completes with reg_write honoured. Then state=101, active=0, stall=1, and pcctl stays 0 thereafter.
- With INSTR_SEQUENCER_PERF_EN: 2 ALU instructions, no waits → instr_count=2, cycle_count=10. Without the macro → both read 0.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: multicycle FETCH/DECODE/EXECUTE/MEMORY_ACCESS/WRITE_BACK control for the MIPS core.
// Latency: 5 cycles per instruction, plus one cycle per waitrequest cycle in FETCH_INSTR or in MEMORY_ACCESS of a load/store.
// Backpressure: waitrequest holds FETCH_INSTR or MEMORY_ACCESS and raises stall. Optional perf counters are enabled by INSTR_SEQUENCER_PERF_EN.
module instr_sequencer #(
  parameter logic [2:0] RESET_STATE = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic        is_mem,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic        halt_req,
  input  logic        needs_wb,
  output logic [2:0]  state,
  output logic        stall,
  output logic        pcctl,
  output logic        PCWriteCond,
  output logic        ir_write,
  output logic        reg_write,
  output logic        branch_pending,
  output logic        active,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    FETCH_INSTR   = 3'b000,
    DECODE        = 3'b001,
    EXECUTE       = 3'b010,
    MEMORY_ACCESS = 3'b011,
    WRITE_BACK    = 3'b100,
    HALTED        = 3'b101
  } state_t;

  state_t state_q, state_d;
  // branch_pending_q: a taken branch whose delay slot has not yet passed MEMORY_ACCESS.
  // in_slot_q: the instruction in flight is that delay slot, so its MEMORY_ACCESS exit retires the branch.
  logic   branch_pending_q, branch_pending_d;
  logic   in_slot_q, in_slot_d;
  logic   halt_armed_q, halt_armed_d;

  // Next-state and branch/halt bookkeeping.
  always_comb begin
    state_d          = state_q;
    branch_pending_d = branch_pending_q;
    in_slot_d        = in_slot_q;
    halt_armed_d     = halt_armed_q;
    case (state_q)
      FETCH_INSTR: begin
        if (!waitrequest) begin
          state_d   = DECODE;
          // A branch still pending at fetch means this new instruction is its delay slot.
          in_slot_d = branch_pending_q;
        end
      end
      DECODE: state_d = EXECUTE;
      EXECUTE: begin
        state_d = MEMORY_ACCESS;
        if (is_branch && branch_taken) begin
          // A taken branch (also one sitting in a delay slot) owns the pending flag afresh.
          branch_pending_d = 1'b1;
          in_slot_d        = 1'b0;
        end
        if (is_branch && halt_req) begin
          halt_armed_d = 1'b1;
        end
      end
      MEMORY_ACCESS: begin
        if (!(is_mem && waitrequest)) begin
          state_d = WRITE_BACK;
          if (in_slot_q) begin
            branch_pending_d = 1'b0;
            in_slot_d        = 1'b0;
          end
        end
      end
      WRITE_BACK: begin
        // The jump's own write-back still has its branch pending; halt after the delay slot.
        if (halt_armed_q && !branch_pending_q) state_d = HALTED;
        else                                   state_d = FETCH_INSTR;
      end
      HALTED:  state_d = HALTED;
      default: state_d = FETCH_INSTR;
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= state_t'(RESET_STATE);
      branch_pending_q <= 1'b0;
      in_slot_q        <= 1'b0;
      halt_armed_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      branch_pending_q <= branch_pending_d;
      in_slot_q        <= in_slot_d;
      halt_armed_q     <= halt_armed_d;
    end
  end

  // Control outputs decoded from the registered state and live inputs; forced quiet while in reset.
  always_comb begin
    pcctl       = 1'b0;
    ir_write    = 1'b0;
    PCWriteCond = 1'b0;
    reg_write   = 1'b0;
    stall       = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH_INSTR: begin
          pcctl    = !waitrequest;
          ir_write = !waitrequest;
          stall    = waitrequest;
        end
        EXECUTE:       PCWriteCond = is_branch && branch_taken;
        MEMORY_ACCESS: stall       = is_mem && waitrequest;
        WRITE_BACK:    reg_write   = needs_wb;
        HALTED:        stall       = 1'b1;
        default:       stall       = 1'b0;
      endcase
    end
  end

  assign state          = state_q;
  assign branch_pending = branch_pending_q;
  assign active         = (state_q != HALTED);

`ifdef INSTR_SEQUENCER_PERF_EN
  logic [31:0] cycle_count_q, instr_count_q;

  // Performance counters; both freeze once halted and wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count_q <= 32'd0;
      instr_count_q <= 32'd0;
    end else if (state_q != HALTED) begin
      cycle_count_q <= cycle_count_q + 32'd1;
      if (state_q == WRITE_BACK) instr_count_q <= instr_count_q + 32'd1;
    end
  end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
`else
  assign cycle_count = 32'd0;
  assign instr_count = 32'd0;
`endif

endmodule
